// File: rtl/instr_prefetch_buffer.sv
`timescale 1ns/1ps
// Instruction prefetch buffer: keeps at most one fetch outstanding and queues
// returned words with their PCs in a two-entry FIFO. Redirects flush and refetch.
module instr_prefetch_buffer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc4,
    input  logic        instr_ready
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } entry_t;

    state_t      state, state_nxt;
    logic [31:0] fetch_pc;
    logic [31:0] req_pc;
    entry_t      fifo_mem [2];
    logic        rd_ptr, wr_ptr;
    logic [1:0]  count;
    logic        issue, push, pop;
    logic        unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign pop = (count != 2'd0) && instr_ready && !redirect;

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        push      = 1'b0;
        unique case (state)
            IDLE: begin
                if (!redirect && count != FULL) begin
                    issue     = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_nxt = IDLE;
                    if (!redirect) begin
                        push = 1'b1;
                        // Chain the next fetch only if the FIFO still has a free slot after this push/pop
                        if (count == 2'd0 || (count == 2'd1 && pop)) begin
                            issue     = 1'b1;
                            state_nxt = WAIT;
                        end
                    end
                end else if (redirect) begin
                    state_nxt = DROP;
                end
            end
            DROP: begin
                if (imem_rvalid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= 2'd0;
        end else begin
            state <= state_nxt;
            if (issue) req_pc <= fetch_pc;
            if (redirect) begin
                fetch_pc <= {redirect_pc[31:2], 2'b00};
                rd_ptr   <= 1'b0;
                wr_ptr   <= 1'b0;
                count    <= 2'd0;
            end else begin
                if (issue) fetch_pc <= fetch_pc + 32'd4;
                if (push)  wr_ptr   <= ~wr_ptr;
                if (pop)   rd_ptr   <= ~rd_ptr;
                count <= count + {1'b0, push} - {1'b0, pop};
            end
        end
    end

    // NOTE: FIFO storage is not reset; its contents are only visible through instr_valid masking.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= '{word: imem_rdata, pc: req_pc};
    end

    assign imem_req    = issue && !rst;
    assign imem_addr   = fetch_pc;
    assign instr_valid = (count != 2'd0);

    always_comb begin
        instr     = '0;
        instr_pc  = '0;
        instr_pc4 = '0;
        if (instr_valid) begin
            instr     = fifo_mem[rd_ptr].word;
            instr_pc  = fifo_mem[rd_ptr].pc;
            instr_pc4 = fifo_mem[rd_ptr].pc + 32'd4;
        end
    end

endmodule
